// File: rtl/onctl_pkg.sv
// Shared types and decode constants for the multi-channel ONCTL latch.
package onctl_pkg;

  // Per-channel latch state.
  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAIT_WAKE = 2'd1,
    ON        = 2'd2,
    FAULT     = 2'd3
  } onctl_state_e;

  // Filtered input code f = {SLP_S3_N, SLP_S4_N, ONCTL_N}.
  localparam logic [2:0] F_ON_REQ = 3'b110;
  localparam logic [2:0] F_REL_S5 = 3'b001;
  localparam logic [2:0] F_REL_S4 = 3'b011;
  localparam logic [2:0] F_REL_S3 = 3'b101;

  // True when ONCTL is released and the platform has left S0.
  function automatic logic f_is_release(input logic [2:0] f);
    f_is_release = (f == F_REL_S5) || (f == F_REL_S4) || (f == F_REL_S3);
  endfunction

endpackage

// File: rtl/onctl_deb.sv
// 1-bit two-flop synchroniser followed by a consecutive-sample debouncer.
// DEBOUNCE_CYC = 0 leaves only the synchroniser in the path.
module onctl_deb
  import onctl_pkg::*;
#(
  parameter int   DEBOUNCE_CYC = 4,
  parameter logic RST_VAL      = 1'b0
) (
  input  logic iClk_2M,
  input  logic iRst_n,
  input  logic raw,
  output logic filt
);

  logic sync1_r;
  logic sync2_r;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge iClk_2M) begin
    if (!iRst_n) begin
      sync1_r <= RST_VAL;
      sync2_r <= RST_VAL;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      assign filt = sync2_r;
    end else begin : g_filter
      localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

      logic [CW-1:0] cnt_r;
      logic          filt_r;

      // Count consecutive disagreeing samples; flip the output on the last one.
      always_ff @(posedge iClk_2M) begin
        if (!iRst_n) begin
          cnt_r  <= {CW{1'b0}};
          filt_r <= RST_VAL;
        end else if (sync2_r == filt_r) begin
          cnt_r  <= {CW{1'b0}};
          filt_r <= filt_r;
        end else if (cnt_r == CNT_LAST) begin
          cnt_r  <= {CW{1'b0}};
          filt_r <= sync2_r;
        end else begin
          cnt_r  <= cnt_r + CW'(1);
          filt_r <= filt_r;
        end
      end

      assign filt = filt_r;
    end
  endgenerate

endmodule

// File: rtl/onctl_latch_mc.sv
// Multi-channel ONCTL latch: conditions BMC/PCH pins per channel, holds the
// latched ONCTL_N low through power-button-override release while the
// platform stays in S0, and flags wakes that never complete.
module onctl_latch_mc
  import onctl_pkg::*;
#(
  parameter int CHANNELS         = 2,
  parameter int DEBOUNCE_CYC     = 4,
  parameter int WAKE_TIMEOUT_CYC = 2000000
) (
  input  logic                iClk_2M,
  input  logic                iRst_n,
  input  logic [CHANNELS-1:0] iEn,
  input  logic [CHANNELS-1:0] iBmcOnctlN,
  input  logic [CHANNELS-1:0] iSlpS3N,
  input  logic [CHANNELS-1:0] iSlpS4N,
  input  logic                iTimeoutClr,
  output logic [CHANNELS-1:0] oOnctlLatchN,
  output logic [CHANNELS-1:0] oWakeTimeout
);

  localparam int TW = (WAKE_TIMEOUT_CYC > 2) ? $clog2(WAKE_TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(WAKE_TIMEOUT_CYC - 1);

  generate
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      logic         onctl_f_s;
      logic         s3_f_s;
      logic         s4_f_s;
      logic [2:0]   f_s;
      onctl_state_e state_r;
      onctl_state_e state_nxt_s;
      logic [TW-1:0] cnt_r;
      logic [TW-1:0] cnt_nxt_s;
      logic         set_s;
      logic         latch_r;
      logic         flag_r;

      onctl_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_deb_onctl (
        .iClk_2M (iClk_2M),
        .iRst_n  (iRst_n),
        .raw     (iBmcOnctlN[ch]),
        .filt    (onctl_f_s)
      );

      onctl_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b0)) u_deb_s3 (
        .iClk_2M (iClk_2M),
        .iRst_n  (iRst_n),
        .raw     (iSlpS3N[ch]),
        .filt    (s3_f_s)
      );

      onctl_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RST_VAL(1'b0)) u_deb_s4 (
        .iClk_2M (iClk_2M),
        .iRst_n  (iRst_n),
        .raw     (iSlpS4N[ch]),
        .filt    (s4_f_s)
      );

      assign f_s = {s3_f_s, s4_f_s, onctl_f_s};

      // State and wake-timeout counter registers.
      always_ff @(posedge iClk_2M) begin
        if (!iRst_n) begin
          state_r <= OFF;
          cnt_r   <= {TW{1'b0}};
        end else begin
          state_r <= state_nxt_s;
          cnt_r   <= cnt_nxt_s;
        end
      end

      // Next-state decode; a wake request beats the timeout in WAIT_WAKE.
      always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        set_s       = 1'b0;
        if (!iEn[ch]) begin
          state_nxt_s = OFF;
          cnt_nxt_s   = {TW{1'b0}};
        end else begin
          case (state_r)
            OFF: begin
              if (f_s == F_ON_REQ) begin
                state_nxt_s = ON;
              end else if (!onctl_f_s) begin
                state_nxt_s = WAIT_WAKE;
                cnt_nxt_s   = {TW{1'b0}};
              end else begin
                state_nxt_s = OFF;
              end
            end
            WAIT_WAKE: begin
              if (f_s == F_ON_REQ) begin
                state_nxt_s = ON;
              end else if (onctl_f_s) begin
                state_nxt_s = OFF;
              end else if (cnt_r == TO_LAST) begin
                // Counter holds at its last value rather than wrapping.
                state_nxt_s = FAULT;
                set_s       = 1'b1;
              end else begin
                cnt_nxt_s   = cnt_r + TW'(1);
              end
            end
            ON: begin
              // ONCTL released while still in S0 (code 111) keeps the latch low.
              if (f_is_release(f_s)) begin
                state_nxt_s = OFF;
              end else begin
                state_nxt_s = ON;
              end
            end
            FAULT: begin
              if (onctl_f_s) begin
                state_nxt_s = OFF;
              end else begin
                state_nxt_s = FAULT;
              end
            end
            default: begin
              state_nxt_s = OFF;
              cnt_nxt_s   = {TW{1'b0}};
            end
          endcase
        end
      end

      // Registered outputs, aligned with the state register; a set beats a clear.
      always_ff @(posedge iClk_2M) begin
        if (!iRst_n) begin
          latch_r <= 1'b1;
          flag_r  <= 1'b0;
        end else begin
          latch_r <= (state_nxt_s != ON);
          if (set_s) begin
            flag_r <= 1'b1;
          end else if (iTimeoutClr) begin
            flag_r <= 1'b0;
          end else begin
            flag_r <= flag_r;
          end
        end
      end

      assign oOnctlLatchN[ch] = latch_r;
      assign oWakeTimeout[ch] = flag_r;
    end
  endgenerate

endmodule

// File: tb/tb_onctl_latch_mc.sv
// Scoreboard bench for onctl_latch_mc: directed sequences followed by random
// pin activity, compared each cycle against a behavioural channel model.
module tb_onctl_latch_mc;

  localparam int CH   = 2;
  localparam int DEB  = 4;
  localparam int TO   = 16;
  localparam int NMAX = 4096;

  localparam int M_OFF   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_ON    = 2;
  localparam int M_FAULT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic [CH-1:0] onctl_n;
  logic [CH-1:0] s3_n;
  logic [CH-1:0] s4_n;
  logic          clr;
  logic [CH-1:0] latch_n;
  logic [CH-1:0] wto;

  onctl_latch_mc #(
    .CHANNELS         (CH),
    .DEBOUNCE_CYC     (DEB),
    .WAKE_TIMEOUT_CYC (TO)
  ) dut (
    .iClk_2M      (clk),
    .iRst_n       (rst_n),
    .iEn          (en),
    .iBmcOnctlN   (onctl_n),
    .iSlpS3N      (s3_n),
    .iSlpS4N      (s4_n),
    .iTimeoutClr  (clr),
    .oOnctlLatchN (latch_n),
    .oWakeTimeout (wto)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] latch;
    logic [CH-1:0] flag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state: raw pin history (as seen by the first sync flop),
  // filtered values, channel mode, cycles spent waiting, sticky flag.
  bit hist [CH][3][NMAX];
  bit mfilt [CH][3];
  int mst [CH];
  int mwait [CH];
  bit mflag [CH];
  int cyc = 0;
  int last_rst = -1;

  function automatic bit rst_val(int s);
    return (s == 0);
  endfunction

  function automatic bit hval(int ch, int s, int idx);
    if (idx < 0 || idx <= last_rst) return rst_val(s);
    return hist[ch][s][idx];
  endfunction

  // Will this channel time out on the coming edge with the present inputs?
  function automatic bit fault_next(int ch);
    bit fo, f3, f4;
    fo = mfilt[ch][0];
    f3 = mfilt[ch][1];
    f4 = mfilt[ch][2];
    return rst_n && en[ch] && (mst[ch] == M_WAIT) && !fo && !(f3 && f4) && (mwait[ch] == TO - 1);
  endfunction

  // Advance the model by one clock edge and queue the expected outputs.
  task automatic model_edge();
    exp_t e;
    if (cyc >= NMAX) begin
      $display("FAIL model_bounds cycle %0d exceeds history size %0d", cyc, NMAX);
      $fatal(1);
    end
    if (!rst_n) begin
      last_rst = cyc;
      for (int ch = 0; ch < CH; ch++) begin
        for (int s = 0; s < 3; s++) mfilt[ch][s] = rst_val(s);
        mst[ch]   = M_OFF;
        mwait[ch] = 0;
        mflag[ch] = 1'b0;
      end
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        bit fo, f3, f4, req, set;
        fo  = mfilt[ch][0];
        f3  = mfilt[ch][1];
        f4  = mfilt[ch][2];
        req = f3 && f4 && !fo;
        set = 1'b0;
        if (!en[ch]) begin
          mst[ch]   = M_OFF;
          mwait[ch] = 0;
        end else begin
          case (mst[ch])
            M_OFF: begin
              if (req) mst[ch] = M_ON;
              else if (!fo) begin mst[ch] = M_WAIT; mwait[ch] = 0; end
            end
            M_WAIT: begin
              if (req) mst[ch] = M_ON;
              else if (fo) mst[ch] = M_OFF;
              else begin
                mwait[ch]++;
                if (mwait[ch] == TO) begin mst[ch] = M_FAULT; set = 1'b1; end
              end
            end
            M_ON:    if (fo && !(f3 && f4)) mst[ch] = M_OFF;
            default: if (fo) mst[ch] = M_OFF;
          endcase
        end
        if (set) mflag[ch] = 1'b1;
        else if (clr) mflag[ch] = 1'b0;
        // Filtered value flips once the last DEB synchronised samples all disagree.
        for (int s = 0; s < 3; s++) begin
          bit raw, flip;
          raw = (s == 0) ? onctl_n[ch] : (s == 1) ? s3_n[ch] : s4_n[ch];
          hist[ch][s][cyc] = raw;
          flip = 1'b1;
          for (int k = cyc - DEB - 1; k <= cyc - 2; k++)
            if (hval(ch, s, k) == mfilt[ch][s]) flip = 1'b0;
          if (flip) mfilt[ch][s] = !mfilt[ch][s];
        end
      end
    end
    for (int ch = 0; ch < CH; ch++) begin
      e.latch[ch] = (mst[ch] != M_ON);
      e.flag[ch]  = mflag[ch];
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(int k);
    repeat (k) step();
  endtask

  // Monitor: one expected entry per edge, compared half a cycle later.
  initial begin
    exp_t e;
    int   mcyc;
    mcyc = 0;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (latch_n !== e.latch) begin
          errors++;
          $display("FAIL latch edge %0d: got %b want %b", mcyc, latch_n, e.latch);
        end
        checks++;
        if (wto !== e.flag) begin
          errors++;
          $display("FAIL wake_timeout edge %0d: got %b want %b", mcyc, wto, e.flag);
        end
        mcyc++;
      end
    end
  end

  // Stimulus: directed scenarios then randomized pin activity.
  initial begin
    rst_n   = 1'b0;
    en      = '1;
    onctl_n = '1;
    s3_n    = '0;
    s4_n    = '0;
    clr     = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(8);

    // Power-on request on ch0.
    s3_n[0] = 1'b1; s4_n[0] = 1'b1;
    run(10);
    onctl_n[0] = 1'b0;
    run(12);

    // Override hold, then release by S3 falling.
    onctl_n[0] = 1'b1;
    run(12);
    s3_n[0] = 1'b0;
    run(12);

    // Glitch rejection: 3-cycle pulse ignored, 5-cycle pulse accepted.
    s3_n[0] = 1'b1;
    run(10);
    onctl_n[0] = 1'b0; run(3);
    onctl_n[0] = 1'b1; run(12);
    onctl_n[0] = 1'b0; run(5);
    onctl_n[0] = 1'b1; run(12);
    s3_n[0] = 1'b0; s4_n[0] = 1'b0;
    run(12);

    // Wake timeout, release, clear; then clear coinciding with the set.
    onctl_n[0] = 1'b0;
    run(30);
    onctl_n[0] = 1'b1;
    run(10);
    clr = 1'b1; step(); clr = 1'b0;
    run(3);
    onctl_n[0] = 1'b0;
    for (int w = 0; w < 100 && !fault_next(0); w++) step();
    clr = 1'b1; step(); clr = 1'b0;
    run(4);
    onctl_n[0] = 1'b1;
    run(10);
    clr = 1'b1; step(); clr = 1'b0;
    run(2);

    // Wake in time from WAIT_WAKE.
    onctl_n[0] = 1'b0;
    for (int w = 0; w < 50 && mst[0] != M_WAIT; w++) step();
    run(7);
    s3_n[0] = 1'b1; s4_n[0] = 1'b1;
    run(12);
    onctl_n[0] = 1'b1; s3_n[0] = 1'b0; s4_n[0] = 1'b0;
    run(12);

    // Enable drop on ch1 while ON, then reset mid-sequence.
    s3_n[1] = 1'b1; s4_n[1] = 1'b1; onctl_n[1] = 1'b0;
    onctl_n[0] = 1'b0;
    run(12);
    en[1] = 1'b0; run(3);
    en[1] = 1'b1; run(10);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    run(12);

    // Randomized pin activity.
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 9) == 0)  onctl_n[ch] = ~onctl_n[ch];
        if ($urandom_range(0, 11) == 0) s3_n[ch] = ~s3_n[ch];
        if ($urandom_range(0, 11) == 0) s4_n[ch] = ~s4_n[ch];
        if (en[ch]) begin
          if ($urandom_range(0, 199) == 0) en[ch] = 1'b0;
        end else begin
          if ($urandom_range(0, 19) == 0) en[ch] = 1'b1;
        end
      end
      clr = ($urandom_range(0, 39) == 0);
      for (int ch = 0; ch < CH; ch++)
        if (fault_next(ch) && $urandom_range(0, 1) == 1) clr = 1'b1;
      step();
    end

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
